proc_hier: RTL and testbench

Top-level processor hierarchy monitor for the 16-bit core. It sits beside the core at the top of the hierarchy and samples the core's per-cycle commit signals: PC, instruction, register write, memory access and halt. From these it maintains a cycle counter, a retired-instruction counter and four cache request/hit counters. It also produces a sticky halted indication with frozen final statistics for the simulation log and trace harness.

---
 rtl/proc_hier_pkg.sv | 22 ++
 rtl/proc_hier_sat_cnt.sv | 36 +++
 rtl/proc_hier.sv | 178 +++++++++++++++++
 tb/tb_proc_hier.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_hier_pkg.sv
// Shared types and defaults for the proc_hier monitor hierarchy.
// Optional cache statistics are enabled by defining PROC_HIER_CACHE_STATS_EN.
package proc_hier_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned REG_IDX_W = 3;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // One registered trace record, describing the previous commit cycle.
    typedef struct packed {
        logic  valid;
        logic  reg_wr;
        logic  load;
        logic  store;
        word_t addr;
        word_t data;
    } trace_t;

endpackage

// File: rtl/proc_hier_sat_cnt.sv
// Saturating up-counter with count enable and freeze; holds at all-ones.
module proc_hier_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         freeze,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only when enabled, not frozen, and not yet saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en && !freeze && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/proc_hier.sv
// Processor hierarchy monitor: cycle/retire/cache statistics, sticky halt,
// and a one-cycle-delayed commit trace. Cache statistics and the
// hit-without-request error are built only with PROC_HIER_CACHE_STATS_EN.
module proc_hier
    import proc_hier_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pc,
    input  logic [15:0]      inst,
    input  logic             reg_write,
    input  logic [2:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data_in,
    input  logic [15:0]      mem_data_out,
    input  logic             halt,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] icache_req_count,
    output logic [CNT_W-1:0] icache_hit_count,
    output logic [CNT_W-1:0] dcache_req_count,
    output logic [CNT_W-1:0] dcache_hit_count,
    output logic             halted,
    output logic             trace_valid,
    output logic             trace_reg,
    output logic             trace_load,
    output logic             trace_store,
    output logic [15:0]      trace_addr,
    output logic [15:0]      trace_data,
    output logic             err_hit_no_req
);

    logic   halted_q;
    logic   halted_d;
    trace_t trace_q;
    trace_t trace_d;
    logic   retire_c;

    // Fetch-side signals are carried for hierarchy visibility only.
    logic   unused_fetch;
    assign unused_fetch = ^{pc, inst, write_reg};

    assign retire_c = halt | reg_write | mem_write;

    // Sticky halt: set on the edge that samples the halt cycle.
    always_comb begin
        halted_d = halted_q | halt;
    end

    // Trace capture; holds its fields and drops valid once halted.
    always_comb begin
        trace_d       = trace_q;
        trace_d.valid = 1'b0;
        if (!halted_q) begin
            trace_d.valid  = reg_write | mem_read | mem_write;
            trace_d.reg_wr = reg_write;
            trace_d.load   = mem_read;
            trace_d.store  = mem_write;
            trace_d.addr   = word_t'(mem_addr);
            if (mem_write) begin
                trace_d.data = word_t'(mem_data_in);
            end else if (mem_read) begin
                trace_d.data = word_t'(mem_data_out);
            end else if (reg_write) begin
                trace_d.data = word_t'(write_data);
            end else begin
                trace_d.data = '0;
            end
        end
    end

    // Halt and trace registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
            trace_q  <= '0;
        end else begin
            halted_q <= halted_d;
            trace_q  <= trace_d;
        end
    end

    proc_hier_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .freeze (halted_q),
        .count  (cycle_count)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_inst_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (retire_c),
        .freeze (halted_q),
        .count  (inst_count)
    );

`ifdef PROC_HIER_CACHE_STATS_EN
    logic err_q;
    logic err_d;

    proc_hier_sat_cnt #(.W(CNT_W)) u_icache_req_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (icache_req),
        .freeze (halted_q),
        .count  (icache_req_count)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_icache_hit_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (icache_hit),
        .freeze (halted_q),
        .count  (icache_hit_count)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_dcache_req_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (dcache_req),
        .freeze (halted_q),
        .count  (dcache_req_count)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_dcache_hit_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (dcache_hit),
        .freeze (halted_q),
        .count  (dcache_hit_count)
    );

    // Sticky protocol error: a hit strobe with no matching request.
    always_comb begin
        err_d = err_q | (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_hit_no_req = err_q;
`else
    logic unused_cache;
    assign unused_cache = ^{icache_req, icache_hit, dcache_req, dcache_hit};

    assign icache_req_count = '0;
    assign icache_hit_count = '0;
    assign dcache_req_count = '0;
    assign dcache_hit_count = '0;
    assign err_hit_no_req   = 1'b0;
`endif

    assign halted      = halted_q;
    assign trace_valid = trace_q.valid;
    assign trace_reg   = trace_q.reg_wr;
    assign trace_load  = trace_q.load;
    assign trace_store = trace_q.store;
    assign trace_addr  = trace_q.addr;
    assign trace_data  = trace_q.data;

endmodule

// File: tb/tb_proc_hier.sv
// Directed self-checking bench for proc_hier: a default-width instance for
// function checks and a 4-bit instance for counter saturation.
module tb_proc_hier;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        halt;
    logic        icache_req;
    logic        icache_hit;
    logic        dcache_req;
    logic        dcache_hit;

    logic [31:0] cycle_count;
    logic [31:0] inst_count;
    logic [31:0] icache_req_count;
    logic [31:0] icache_hit_count;
    logic [31:0] dcache_req_count;
    logic [31:0] dcache_hit_count;
    logic        halted;
    logic        trace_valid;
    logic        trace_reg;
    logic        trace_load;
    logic        trace_store;
    logic [15:0] trace_addr;
    logic [15:0] trace_data;
    logic        err_hit_no_req;

    logic        rst_s;
    logic [3:0]  s_cycle_count;
    logic [3:0]  s_inst_count;
    logic [3:0]  s_icache_req_count;
    logic [3:0]  s_icache_hit_count;
    logic [3:0]  s_dcache_req_count;
    logic [3:0]  s_dcache_hit_count;
    logic        s_halted;
    logic        s_trace_valid;
    logic        s_trace_reg;
    logic        s_trace_load;
    logic        s_trace_store;
    logic [15:0] s_trace_addr;
    logic [15:0] s_trace_data;
    logic        s_err_hit_no_req;

    int tests_run;
    int tests_failed;

`ifdef PROC_HIER_CACHE_STATS_EN
    localparam logic [31:0] EXP_IREQ = 32'd4;
    localparam logic [31:0] EXP_IHIT = 32'd5;
    localparam logic [31:0] EXP_DREQ = 32'd4;
    localparam logic [31:0] EXP_ERR  = 32'd1;
`else
    localparam logic [31:0] EXP_IREQ = 32'd0;
    localparam logic [31:0] EXP_IHIT = 32'd0;
    localparam logic [31:0] EXP_DREQ = 32'd0;
    localparam logic [31:0] EXP_ERR  = 32'd0;
`endif

    proc_hier #(.CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .inst             (inst),
        .reg_write        (reg_write),
        .write_reg        (write_reg),
        .write_data       (write_data),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .halt             (halt),
        .icache_req       (icache_req),
        .icache_hit       (icache_hit),
        .dcache_req       (dcache_req),
        .dcache_hit       (dcache_hit),
        .cycle_count      (cycle_count),
        .inst_count       (inst_count),
        .icache_req_count (icache_req_count),
        .icache_hit_count (icache_hit_count),
        .dcache_req_count (dcache_req_count),
        .dcache_hit_count (dcache_hit_count),
        .halted           (halted),
        .trace_valid      (trace_valid),
        .trace_reg        (trace_reg),
        .trace_load       (trace_load),
        .trace_store      (trace_store),
        .trace_addr       (trace_addr),
        .trace_data       (trace_data),
        .err_hit_no_req   (err_hit_no_req)
    );

    proc_hier #(.CNT_W(4)) dut_small (
        .clk              (clk),
        .rst              (rst_s),
        .pc               (16'h0000),
        .inst             (16'h0000),
        .reg_write        (1'b0),
        .write_reg        (3'd0),
        .write_data       (16'h0000),
        .mem_read         (1'b0),
        .mem_write        (1'b0),
        .mem_addr         (16'h0000),
        .mem_data_in      (16'h0000),
        .mem_data_out     (16'h0000),
        .halt             (1'b0),
        .icache_req       (1'b0),
        .icache_hit       (1'b0),
        .dcache_req       (1'b0),
        .dcache_hit       (1'b0),
        .cycle_count      (s_cycle_count),
        .inst_count       (s_inst_count),
        .icache_req_count (s_icache_req_count),
        .icache_hit_count (s_icache_hit_count),
        .dcache_req_count (s_dcache_req_count),
        .dcache_hit_count (s_dcache_hit_count),
        .halted           (s_halted),
        .trace_valid      (s_trace_valid),
        .trace_reg        (s_trace_reg),
        .trace_load       (s_trace_load),
        .trace_store      (s_trace_store),
        .trace_addr       (s_trace_addr),
        .trace_data       (s_trace_data),
        .err_hit_no_req   (s_err_hit_no_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        rst_s        = 1'b0;
        pc           = 16'h0100;
        inst         = 16'h0000;
        reg_write    = 1'b0;
        write_reg    = 3'd0;
        write_data   = 16'h0000;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;
        mem_data_out = 16'h0000;
        halt         = 1'b0;
        icache_req   = 1'b0;
        icache_hit   = 1'b0;
        dcache_req   = 1'b0;
        dcache_hit   = 1'b0;

        // Reset hold
        step(3);
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_inst", inst_count, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_tvalid", {31'd0, trace_valid}, 32'd0);
        check("rst_err", {31'd0, err_hit_no_req}, 32'd0);

        // Ten idle cycles
        rst = 1'b1;
        step(10);
        check("idle_cycle", cycle_count, 32'd10);
        check("idle_inst", inst_count, 32'd0);
        check("idle_ireq", icache_req_count, 32'd0);
        check("idle_tvalid", {31'd0, trace_valid}, 32'd0);

        // Three register writes
        reg_write  = 1'b1;
        write_reg  = 3'd5;
        write_data = 16'hABCD;
        step(1);
        check("rw_tvalid", {31'd0, trace_valid}, 32'd1);
        check("rw_treg", {31'd0, trace_reg}, 32'd1);
        check("rw_tdata", {16'd0, trace_data}, 32'h0000ABCD);
        step(2);
        check("rw_inst", inst_count, 32'd3);

        // Two stores
        reg_write   = 1'b0;
        mem_write   = 1'b1;
        mem_addr    = 16'h0010;
        mem_data_in = 16'h5555;
        step(2);
        check("st_tstore", {31'd0, trace_store}, 32'd1);
        check("st_tload", {31'd0, trace_load}, 32'd0);
        check("st_taddr", {16'd0, trace_addr}, 32'h00000010);
        check("st_tdata", {16'd0, trace_data}, 32'h00005555);
        check("st_inst", inst_count, 32'd5);

        // Halt
        mem_write = 1'b0;
        halt      = 1'b1;
        step(1);
        check("halt_inst", inst_count, 32'd6);
        check("halt_cycle", cycle_count, 32'd16);
        check("halt_flag", {31'd0, halted}, 32'd1);

        // Frozen after halt, even with activity on the inputs
        halt      = 1'b0;
        reg_write = 1'b1;
        step(5);
        check("frz_cycle", cycle_count, 32'd16);
        check("frz_inst", inst_count, 32'd6);
        check("frz_halted", {31'd0, halted}, 32'd1);
        check("frz_tvalid", {31'd0, trace_valid}, 32'd0);
        check("frz_treg", {31'd0, trace_reg}, 32'd0);

        // Asynchronous reset mid-run
        reg_write = 1'b0;
        rst       = 1'b0;
        #1;
        check("arst_cycle", cycle_count, 32'd0);
        check("arst_inst", inst_count, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b1;
        step(3);
        check("restart_cycle", cycle_count, 32'd3);

        // Single load
        mem_read     = 1'b1;
        mem_addr     = 16'h0040;
        mem_data_out = 16'h1234;
        mem_data_in  = 16'h9999;
        step(1);
        check("ld_tvalid", {31'd0, trace_valid}, 32'd1);
        check("ld_tload", {31'd0, trace_load}, 32'd1);
        check("ld_tstore", {31'd0, trace_store}, 32'd0);
        check("ld_taddr", {16'd0, trace_addr}, 32'h00000040);
        check("ld_tdata", {16'd0, trace_data}, 32'h00001234);
        check("ld_inst", inst_count, 32'd0);

        // Load and store in the same cycle: store data wins
        mem_write   = 1'b1;
        mem_data_in = 16'h7777;
        step(1);
        check("ldst_tload", {31'd0, trace_load}, 32'd1);
        check("ldst_tstore", {31'd0, trace_store}, 32'd1);
        check("ldst_tdata", {16'd0, trace_data}, 32'h00007777);
        check("ldst_inst", inst_count, 32'd1);

        // Cache strobes
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        icache_req = 1'b1;
        icache_hit = 1'b1;
        dcache_req = 1'b1;
        step(4);
        check("c_err_clean", {31'd0, err_hit_no_req}, 32'd0);
        icache_req = 1'b0;
        dcache_req = 1'b0;
        step(1);
        icache_hit = 1'b0;
        check("c_ireq", icache_req_count, EXP_IREQ);
        check("c_ihit", icache_hit_count, EXP_IHIT);
        check("c_dreq", dcache_req_count, EXP_DREQ);
        check("c_dhit", dcache_hit_count, 32'd0);
        check("c_err", {31'd0, err_hit_no_req}, EXP_ERR);
        step(2);
        check("c_err_sticky", {31'd0, err_hit_no_req}, EXP_ERR);

        // Saturation on the 4-bit instance
        rst_s = 1'b1;
        step(14);
        check("sat_14", {28'd0, s_cycle_count}, 32'd14);
        step(6);
        check("sat_20", {28'd0, s_cycle_count}, 32'd15);
        check("sat_inst", {28'd0, s_inst_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
